// File: rtl/sqw_pkg.sv
// Shared types and defaults for the square-wave measurement block.
package sqw_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MEAS_HIGH,
      MEAS_LOW
   } sqw_state_t;

   localparam int SQW_CNT_W       = 16;
   localparam int SQW_TIMEOUT_CYC = 1000;
   localparam int SQW_SYNC_DEPTH  = 2;

endpackage

// File: rtl/sqw_sync_edge.sv
// Input synchronizer, optional glitch filter (SQW_MEAS_GLITCH_FILTER_EN) and edge detector.
// s is the clean level the measurement counts high time against.
module sqw_sync_edge
   import sqw_pkg::*;
`ifdef SQW_MEAS_GLITCH_FILTER_EN
#(
   parameter int FILT_LEN = 3
)
`endif
(
   input  logic clk,
   input  logic reset,
   input  logic sig_in,
   output logic s,
   output logic rise,
   output logic fall
);

   logic [SQW_SYNC_DEPTH-1:0] sync_q;
   logic                      s_raw;
   logic                      s_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SQW_SYNC_DEPTH-2:0], sig_in};
      end
   end

   assign s_raw = sync_q[SQW_SYNC_DEPTH-1];

`ifdef SQW_MEAS_GLITCH_FILTER_EN
   localparam int FW = $clog2(FILT_LEN + 1);

   logic [FW-1:0] fcnt;
   logic          lvl;

   // The level only follows s_raw after FILT_LEN consecutive disagreeing samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fcnt <= '0;
         lvl  <= 1'b0;
      end else if (s_raw == lvl) begin
         fcnt <= '0;
      end else if (fcnt == FW'(FILT_LEN - 1)) begin
         lvl  <= s_raw;
         fcnt <= '0;
      end else begin
         fcnt <= fcnt + FW'(1);
      end
   end

   assign s = lvl;
`else
   assign s = s_raw;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_d <= 1'b0;
      end else begin
         s_d <= s;
      end
   end

   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

endmodule

// File: rtl/square_wave_meas.sv
// Measures period and high time of a square wave in clk cycles and flags a stalled input.
// Optional glitch filter enabled with `define SQW_MEAS_GLITCH_FILTER_EN.
module square_wave_meas
   import sqw_pkg::*;
#(
   parameter int CNT_W       = SQW_CNT_W,
   parameter int TIMEOUT_CYC = SQW_TIMEOUT_CYC,
   parameter int FILT_LEN    = 3
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

   if (TIMEOUT_CYC < 2 || longint'(TIMEOUT_CYC) > ((longint'(1) << CNT_W) - 1) || FILT_LEN < 1) begin : g_bad_params
      $error("square_wave_meas: illegal parameter combination");
   end

   logic             s;
   logic             rise;
   logic             fall;
   sqw_state_t       state_q;
   sqw_state_t       state_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hcnt;
   logic             complete;
   logic             trip;

`ifdef SQW_MEAS_GLITCH_FILTER_EN
   sqw_sync_edge #(
      .FILT_LEN (FILT_LEN)
   ) u_sync_edge (
      .clk    (clk),
      .reset  (reset),
      .sig_in (sig_in),
      .s      (s),
      .rise   (rise),
      .fall   (fall)
   );
`else
   sqw_sync_edge u_sync_edge (
      .clk    (clk),
      .reset  (reset),
      .sig_in (sig_in),
      .s      (s),
      .rise   (rise),
      .fall   (fall)
   );
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A rise always wins over the timeout; an unexpected rise in MEAS_HIGH still completes.
   always_comb begin
      state_d  = state_q;
      complete = 1'b0;
      trip     = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = MEAS_HIGH;
            end
         end
         MEAS_HIGH: begin
            if (rise) begin
               complete = 1'b1;
               state_d  = MEAS_HIGH;
            end else if (cnt == TO_VAL) begin
               trip    = 1'b1;
               state_d = IDLE;
            end else if (fall) begin
               state_d = MEAS_LOW;
            end
         end
         MEAS_LOW: begin
            if (rise) begin
               complete = 1'b1;
               state_d  = MEAS_HIGH;
            end else if (cnt == TO_VAL) begin
               trip    = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Counting stops on a trip, so cnt never exceeds TIMEOUT_CYC and cannot wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         hcnt <= '0;
      end else if (rise) begin
         cnt  <= CNT_W'(1);
         hcnt <= CNT_W'(1);
      end else if (state_q != IDLE && !trip) begin
         cnt  <= cnt + CNT_W'(1);
         hcnt <= hcnt + CNT_W'(s);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         meas_valid <= complete;
         if (complete) begin
            period    <= cnt;
            high_time <= hcnt;
            timeout   <= 1'b0;
         end else if (trip) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_square_wave_meas.sv
// Self-checking bench for square_wave_meas (default build, glitch filter disabled).
`timescale 1ns/1ps
module tb_square_wave_meas;

   localparam int CNT_W       = 16;
   localparam int TIMEOUT_CYC = 1000;

   typedef struct packed {
      logic [CNT_W-1:0] p;
      logic [CNT_W-1:0] h;
   } exp_t;

   typedef struct {
      int h;
      int l;
      int n;
      int exp_p;
      int exp_h;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             sig_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             timeout;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   bit   armed = 0;
   int   last_p = 0;
   int   last_h = 0;
   vec_t vecs[5];

   square_wave_meas #(
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .FILT_LEN    (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sig_in     (sig_in),
      .period     (period),
      .high_time  (high_time),
      .meas_valid (meas_valid),
      .timeout    (timeout)
   );

   always #125 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // A rise closes the previous cycle unless that cycle was long enough to time out.
   task automatic doRise(input int exp_p, input int exp_h);
      exp_t e;
      sig_in = 1'b1;
      if (armed && last_p <= TIMEOUT_CYC) begin
         e.p = CNT_W'(last_p);
         e.h = CNT_W'(last_h);
         sb.push_back(e);
      end
      armed  = 1'b1;
      last_p = exp_p;
      last_h = exp_h;
   endtask

   task automatic applyStimulus(input int h, input int l, input int exp_p, input int exp_h);
      doRise(exp_p, exp_h);
      repeat (h) @(negedge clk);
      sig_in = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      checkOutput(name, sb.size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && meas_valid) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_valid", meas_valid, 0);
         end else begin
            e = sb.pop_front();
            checkOutput("period", period, e.p);
            checkOutput("high_time", high_time, e.h);
         end
      end
   end

   initial begin
      vecs[0] = '{4, 4, 6, 8, 4};
      vecs[1] = '{3, 7, 5, 10, 3};
      vecs[2] = '{1, 1, 4, 2, 1};
      vecs[3] = '{2, 5, 3, 7, 2};
      vecs[4] = '{6, 2, 3, 8, 6};

      reset  = 1'b1;
      sig_in = 1'b0;
      #450;
      checkOutput("rst_period", period, 0);
      checkOutput("rst_high_time", high_time, 0);
      checkOutput("rst_meas_valid", meas_valid, 0);
      checkOutput("rst_timeout", timeout, 0);
      #50;
      reset = 1'b0;
      repeat (2) @(negedge clk);

      foreach (vecs[k]) begin
         for (int j = 0; j < vecs[k].n; j++) begin
            applyStimulus(vecs[k].h, vecs[k].l, vecs[k].exp_p, vecs[k].exp_h);
         end
      end

      // Stalled high input trips the timeout; it clears only on the next completed cycle.
      applyStimulus(1200, 4, 1204, 1200);
      checkOutput("timeout_set", timeout, 1);
      applyStimulus(4, 4, 8, 4);
      checkOutput("timeout_held_after_rearm", timeout, 1);
      applyStimulus(4, 4, 8, 4);
      checkOutput("timeout_cleared", timeout, 0);

      // Rise landing exactly on the timeout count completes instead of tripping.
      applyStimulus(500, 500, 1000, 500);
      applyStimulus(4, 4, 8, 4);
      checkOutput("no_timeout_at_limit", timeout, 0);

      // One clock beyond the limit trips.
      applyStimulus(500, 501, 1001, 500);
      applyStimulus(4, 4, 8, 4);
      checkOutput("timeout_one_past_limit", timeout, 1);
      applyStimulus(4, 4, 8, 4);
      checkOutput("timeout_cleared_again", timeout, 0);
      waitDrain("sb_drain_pre_reset");

      // Reset in the low phase of a running measurement.
      applyStimulus(4, 2, 8, 4);
      waitDrain("sb_drain_mid_reset");
      reset = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("mid_rst_period", period, 0);
      checkOutput("mid_rst_high_time", high_time, 0);
      checkOutput("mid_rst_meas_valid", meas_valid, 0);
      checkOutput("mid_rst_timeout", timeout, 0);
      reset = 1'b0;
      sb.delete();
      armed = 1'b0;
      repeat (2) @(negedge clk);
      applyStimulus(4, 4, 8, 4);
      checkOutput("no_output_after_first_edge", period, 0);
      applyStimulus(4, 4, 8, 4);
      applyStimulus(3, 7, 10, 3);
      doRise(8, 4);
      repeat (4) @(negedge clk);
      sig_in = 1'b0;
      waitDrain("sb_drain_final");
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
